instruction_fetch_unit: RTL and testbench

//  Read-side master of the combinational instruction memory. Owns the PC and drives

---
 rtl/instruction_fetch_unit_if.sv | 18 +
 rtl/instruction_fetch_unit.sv | 76 +++++++
 tb/tb_instruction_fetch_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
// The memory answers combinationally within the cycle that the address is presented.
interface instruction_fetch_unit_if #(
   parameter int unsigned AW = 32
);
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_instr;

   modport master (
      output imem_addr,
      input  imem_instr
   );

   modport slave (
      input  imem_addr,
      output imem_instr
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory, resolves JMP locally,
// and fills the IF/ID register; honours stalls, execute redirects and range faults.
module instruction_fetch_unit #(
   parameter int unsigned    AW         = 32,
   parameter int unsigned    IMEM_DEPTH = 100,
   parameter logic [AW-1:0]  RESET_PC   = '0,
   parameter logic [5:0]     OP_JMP     = 6'b101010
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall,
   input  logic                     ex_redirect,
   input  logic [AW-1:0]            ex_target,
   instruction_fetch_unit_if.master imem,
   output logic [31:0]              ifid_instr,
   output logic [AW-1:0]            ifid_pc,
   output logic                     ifid_valid,
   output logic                     fetch_fault
);

   localparam logic [AW-1:0] DEPTH_W = AW'(IMEM_DEPTH);

   logic [AW-1:0] pc_reg;
   logic [31:0]   ifid_instr_reg;
   logic [AW-1:0] ifid_pc_reg;
   logic          ifid_valid_reg;
   logic          fault_reg;

   logic          in_range;
   logic          jmp;
   logic [AW-1:0] imm_ext;
   logic [AW-1:0] jmp_tgt;
   logic [AW-1:0] pc_next;
   logic          unused_instr_bits;

   assign imem.imem_addr = pc_reg;

   // The opcode is only trusted while the PC addresses a real instruction word.
   assign in_range = (pc_reg < DEPTH_W);
   assign jmp      = (imem.imem_instr[31:26] == OP_JMP) && in_range;
   assign imm_ext  = {{(AW-16){imem.imem_instr[15]}}, imem.imem_instr[15:0]};
   assign jmp_tgt  = pc_reg + imm_ext;
   assign pc_next  = jmp ? jmp_tgt : (pc_reg + AW'(1));

   assign unused_instr_bits = ^imem.imem_instr[25:16];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_reg         <= RESET_PC;
         ifid_instr_reg <= '0;
         ifid_pc_reg    <= '0;
         ifid_valid_reg <= 1'b0;
         fault_reg      <= 1'b0;
      end else if (ex_redirect) begin
         // Flush only: the stale IF/ID payload is left in place under valid=0.
         pc_reg         <= ex_target;
         ifid_valid_reg <= 1'b0;
      end else if (!stall) begin
         if (!in_range) begin
            fault_reg      <= 1'b1;
            ifid_valid_reg <= 1'b0;
         end else begin
            ifid_instr_reg <= imem.imem_instr;
            ifid_pc_reg    <= pc_reg;
            ifid_valid_reg <= 1'b1;
            pc_reg         <= pc_next;
         end
      end
   end

   assign ifid_instr  = ifid_instr_reg;
   assign ifid_pc     = ifid_pc_reg;
   assign ifid_valid  = ifid_valid_reg;
   assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector tables, corner
// sequences and a randomized run against a behavioural fetch model.
module tb_instruction_fetch_unit;

   localparam int unsigned   DEPTH    = 100;
   localparam logic [31:0]   OOR_WORD = {6'b101010, 10'd0, 16'd5};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        ex_redirect = 1'b0;
   logic [31:0] ex_target = '0;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic        ifid_valid;
   logic        fetch_fault;

   logic [31:0] mem [128];

   instruction_fetch_unit_if #(.AW(32)) bus ();

   assign bus.imem_instr = (bus.imem_addr < 32'd128) ? mem[bus.imem_addr[6:0]] : OOR_WORD;

   instruction_fetch_unit #(
      .AW(32), .IMEM_DEPTH(DEPTH), .RESET_PC(32'd0), .OP_JMP(6'b101010)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .ex_redirect(ex_redirect),
      .ex_target(ex_target), .imem(bus), .ifid_instr(ifid_instr),
      .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   logic [31:0] m_pc = '0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_ipc = '0;
   logic        m_valid = 1'b0;
   logic        m_fault = 1'b0;

   typedef struct {
      bit          rst_n;
      bit          stall;
      bit          redir;
      logic [31:0] tgt;
      logic [31:0] e_pc;
      bit          e_valid;
      logic [31:0] e_ipc;
      bit          e_fault;
   } vec_t;

   vec_t tab_a[$];
   vec_t tab_b[$];

   function automatic logic [31:0] jmp_word(input logic [15:0] imm);
      return {6'b101010, 10'd0, imm};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return (a < 32'd128) ? mem[a[6:0]] : OOR_WORD;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // One clock edge of the fetch rules, taken from the current model state and inputs.
   task automatic model_edge();
      logic [31:0] instr;
      instr = mem_rd(m_pc);
      if (!rst_n) begin
         m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_fault = 0;
      end else if (ex_redirect) begin
         m_pc = ex_target; m_valid = 0;
      end else if (stall) begin
         // everything holds
      end else if (m_pc >= DEPTH) begin
         m_fault = 1; m_valid = 0;
      end else begin
         m_instr = instr; m_ipc = m_pc; m_valid = 1;
         if (instr[31:26] == 6'b101010)
            m_pc = m_pc + 32'($signed(instr[15:0]));
         else
            m_pc = m_pc + 1;
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      check("model_pc", bus.imem_addr, m_pc);
      check("model_valid", 32'(ifid_valid), 32'(m_valid));
      check("model_ifid_pc", ifid_pc, m_ipc);
      check("model_ifid_instr", ifid_instr, m_instr);
      check("model_fault", 32'(fetch_fault), 32'(m_fault));
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      rst_n = v.rst_n; stall = v.stall; ex_redirect = v.redir; ex_target = v.tgt;
      cyc();
      check("vec_pc", bus.imem_addr, v.e_pc);
      check("vec_valid", 32'(ifid_valid), 32'(v.e_valid));
      check("vec_ifid_pc", ifid_pc, v.e_ipc);
      check("vec_fault", 32'(fetch_fault), 32'(v.e_fault));
      $display("vec %0d: rst_n=%0d stall=%0d redir=%0d tgt=%0d -> pc=%0d valid=%0d ifid_pc=%0d fault=%0d",
               idx, v.rst_n, v.stall, v.redir, v.tgt, bus.imem_addr, ifid_valid, ifid_pc, fetch_fault);
   endtask

   task automatic load_default();
      for (int i = 0; i < 128; i++) mem[i] = 32'h0100_0000 + 32'(i);
   endtask

   initial begin
      load_default();

      // T1 reset with stall and redirect active, then T2 straight-line fetch
      tab_a.push_back('{0, 1, 1, 32'd55, 32'd0, 0, 32'd0, 0});
      tab_a.push_back('{0, 1, 1, 32'd55, 32'd0, 0, 32'd0, 0});
      tab_a.push_back('{1, 0, 0, 32'd0,  32'd1, 1, 32'd0, 0});
      tab_a.push_back('{1, 0, 0, 32'd0,  32'd2, 1, 32'd1, 0});
      tab_a.push_back('{1, 0, 0, 32'd0,  32'd3, 1, 32'd2, 0});
      tab_a.push_back('{1, 0, 0, 32'd0,  32'd4, 1, 32'd3, 0});

      // T3 jump loop, T4 redirect beats stall, T5 out of range, T6 reset on a JMP
      tab_b.push_back('{0, 0, 0, 32'd0,   32'd0,   0, 32'd0, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd3,   1, 32'd0, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd4,   1, 32'd3, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd1,   1, 32'd4, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd2,   1, 32'd1, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd3,   1, 32'd2, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd4,   1, 32'd3, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd1,   1, 32'd4, 0});
      tab_b.push_back('{1, 1, 1, 32'd7,   32'd7,   0, 32'd4, 0});
      tab_b.push_back('{1, 1, 0, 32'd0,   32'd7,   0, 32'd4, 0});
      tab_b.push_back('{1, 1, 0, 32'd0,   32'd7,   0, 32'd4, 0});
      tab_b.push_back('{1, 1, 0, 32'd0,   32'd7,   0, 32'd4, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd8,   1, 32'd7, 0});
      tab_b.push_back('{1, 0, 1, 32'd100, 32'd100, 0, 32'd7, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd100, 0, 32'd7, 1});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd100, 0, 32'd7, 1});
      tab_b.push_back('{1, 0, 1, 32'd2,   32'd2,   0, 32'd7, 1});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd3,   1, 32'd2, 1});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd4,   1, 32'd3, 1});
      tab_b.push_back('{0, 0, 0, 32'd0,   32'd0,   0, 32'd0, 0});
      tab_b.push_back('{1, 0, 0, 32'd0,   32'd3,   1, 32'd0, 0});

      foreach (tab_a[i]) run_vec(tab_a[i], i);

      mem[0] = jmp_word(16'd3);
      mem[4] = jmp_word(16'hFFFD);
      foreach (tab_b[i]) run_vec(tab_b[i], 100 + i);

      // JMP and redirect in the same cycle: pc is now 3, step onto the JMP at 4
      rst_n = 1; stall = 0; ex_redirect = 0;
      cyc();
      check("pre_jmp_pc", bus.imem_addr, 32'd4);
      ex_redirect = 1; ex_target = 32'd9;
      cyc();
      check("jmp_vs_redir_pc", bus.imem_addr, 32'd9);
      check("jmp_vs_redir_valid", 32'(ifid_valid), 32'd0);
      $display("seq jmp+redirect: pc=%0d valid=%0d", bus.imem_addr, ifid_valid);

      // Backward JMP from pc 0 wraps the PC, then the range fault fires
      mem[0] = jmp_word(16'hFFFF);
      ex_target = 32'd0;
      cyc();
      ex_redirect = 0;
      cyc();
      check("wrap_pc", bus.imem_addr, 32'hFFFF_FFFF);
      check("wrap_valid", 32'(ifid_valid), 32'd1);
      check("wrap_fault_early", 32'(fetch_fault), 32'd0);
      cyc();
      check("wrap_fault", 32'(fetch_fault), 32'd1);
      check("wrap_parked", bus.imem_addr, 32'hFFFF_FFFF);
      $display("seq wrap: pc=%0h fault=%0d", bus.imem_addr, fetch_fault);

      // Randomized program and control traffic against the model
      for (int i = 0; i < 128; i++) begin
         if ($urandom_range(0, 3) == 0)
            mem[i] = jmp_word(16'($signed($urandom_range(0, 8)) - 4));
         else
            mem[i] = $urandom() & 32'h03FF_FFFF;
      end
      rst_n = 0; stall = 0; ex_redirect = 0;
      cyc();
      for (int n = 0; n < 3000; n++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         stall       = ($urandom_range(0, 4) == 0);
         ex_redirect = ($urandom_range(0, 9) == 0);
         ex_target   = 32'($urandom_range(0, 110));
         cyc();
      end
      $display("random run done: checks so far %0d", checks);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
